button_conditioner: RTL and testbench

Conditions the five raw push-button inputs (centre, up, down, left, right) before they reach the minesweeper game FSM. It synchronises and debounces each input and converts presses into single-cycle event pulses: the centre button is classified as short or long press, and the direction buttons get auto-repeat while held. Its outputs drive `button_c_short`, `button_c_long`, `button_u/d/l/r` of `game_fsm` directly, in the same clock domain.

---
 rtl/button_conditioner_if.sv | 28 ++
 rtl/button_conditioner.sv | 150 +++++++++++++++
 tb/tb_button_conditioner.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Raw push-button levels in, conditioned event pulses and debounced levels out.
// master: the conditioner side; slave: the game FSM side.
interface button_conditioner_if;
  logic       btn_c_raw;
  logic       btn_u_raw;
  logic       btn_d_raw;
  logic       btn_l_raw;
  logic       btn_r_raw;
  logic       button_c_short;
  logic       button_c_long;
  logic       button_u;
  logic       button_d;
  logic       button_l;
  logic       button_r;
  logic [4:0] buttons_stable;

  modport master (
    input  btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw,
    output button_c_short, button_c_long, button_u, button_d, button_l, button_r,
    output buttons_stable
  );

  modport slave (
    output btn_c_raw, btn_u_raw, btn_d_raw, btn_l_raw, btn_r_raw,
    input  button_c_short, button_c_long, button_u, button_d, button_l, button_r,
    input  buttons_stable
  );
endinterface

// File: rtl/button_conditioner.sv
// Sync + debounce five buttons; centre short/long classification, direction auto-repeat.
// Press pulse DEBOUNCE_CYCLES+3 edges after a raw change; no backpressure, pulses are one cycle.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 360000,
  parameter int LONG_PRESS_CYCLES    = 36000000,
  parameter int REPEAT_DELAY_CYCLES  = 18000000,
  parameter int REPEAT_PERIOD_CYCLES = 5400000,
  parameter bit REPEAT_EN            = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.master btn
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW   = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST   = LW'(LONG_PRESS_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_HELD       = 2'd1;
  localparam logic [1:0] ST_LONG_FIRED = 2'd2;

  // Bit order {c,u,d,l,r}, MSB = centre.
  logic [4:0]    raw;
  logic [4:0]    sync_q1;
  logic [4:0]    sync_q2;
  logic [4:0]    stable;
  logic [4:0]    stable_d;
  logic [4:0]    rise;
  logic [DW-1:0] db_cnt [5];

  logic [3:0]    dir_pulse;
  logic [3:0]    rep_armed;
  logic [RW-1:0] rep_cnt [4];

  logic [1:0]    state;
  logic [LW-1:0] hold_cnt;
  logic          c_short_q;
  logic          c_long_q;

  assign raw  = {btn.btn_c_raw, btn.btn_u_raw, btn.btn_d_raw, btn.btn_l_raw, btn.btn_r_raw};
  assign rise = stable & ~stable_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_q1  <= raw;
      sync_q2  <= sync_q1;
      stable_d <= stable;
      for (int i = 0; i < 5; i++) begin
        if (sync_q2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // rep_armed marks that the initial delay has elapsed and the period applies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_pulse <= '0;
      rep_armed <= '0;
      for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        dir_pulse[i] <= 1'b0;
        if (!stable[i]) begin
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b0;
        end else if (rise[i]) begin
          dir_pulse[i] <= 1'b1;
          rep_cnt[i]   <= '0;
          rep_armed[i] <= 1'b0;
        end else if (REPEAT_EN) begin
          if (rep_cnt[i] == (rep_armed[i] ? PERIOD_LAST : DELAY_LAST)) begin
            dir_pulse[i] <= 1'b1;
            rep_cnt[i]   <= '0;
            rep_armed[i] <= 1'b1;
          end else begin
            rep_cnt[i] <= rep_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Threshold is tested before release so a coincident release still reports long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      c_short_q <= 1'b0;
      c_long_q  <= 1'b0;
    end else begin
      c_short_q <= 1'b0;
      c_long_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise[4]) begin
            state    <= ST_HELD;
            hold_cnt <= '0;
          end
        end
        ST_HELD: begin
          if (hold_cnt == LONG_LAST) begin
            c_long_q <= 1'b1;
            state    <= ST_LONG_FIRED;
            hold_cnt <= '0;
          end else if (!stable[4]) begin
            c_short_q <= 1'b1;
            state     <= ST_IDLE;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_LONG_FIRED: begin
          if (!stable[4]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign btn.button_c_short = c_short_q;
  assign btn.button_c_long  = c_long_q;
  assign btn.button_u       = dir_pulse[3];
  assign btn.button_d       = dir_pulse[2];
  assign btn.button_l       = dir_pulse[1];
  assign btn.button_r       = dir_pulse[0];
  assign btn.buttons_stable = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed-vector bench for button_conditioner with DEBOUNCE=4, LONG=20, DELAY=10, PERIOD=5.
// Edges are counted from the first posedge after a raw change; outputs sampled 1 ns after each edge.
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst;
  logic c_raw, u_raw, d_raw, l_raw, r_raw;
  int   total = 0;
  int   bad   = 0;

  button_conditioner_if bif ();
  button_conditioner_if bif_nr ();

  assign bif.btn_c_raw    = c_raw;
  assign bif.btn_u_raw    = u_raw;
  assign bif.btn_d_raw    = d_raw;
  assign bif.btn_l_raw    = l_raw;
  assign bif.btn_r_raw    = r_raw;
  assign bif_nr.btn_c_raw = c_raw;
  assign bif_nr.btn_u_raw = u_raw;
  assign bif_nr.btn_d_raw = d_raw;
  assign bif_nr.btn_l_raw = l_raw;
  assign bif_nr.btn_r_raw = r_raw;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn(bif)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn(bif_nr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [4:0] v);
    {c_raw, u_raw, d_raw, l_raw, r_raw} = v;
  endtask

  function automatic logic [10:0] outs();
    return {bif.button_c_short, bif.button_c_long, bif.button_u, bif.button_d,
            bif.button_l, bif.button_r, bif.buttons_stable};
  endfunction

  int n_r, n_nr;

  initial begin
    // Reset with every button pressed: outputs clear before any clock edge.
    rst = 1'b1;
    set_raw(5'b11111);
    #1;
    check_val("rst_async_outs", 32'(outs()), 32'h0);
    repeat (3) tick();
    check_val("rst_held_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_val("rst_new_press_u", 32'(bif.button_u), 32'(t == DB + 3));
      check_val("rst_new_stable", 32'(bif.buttons_stable), (t >= DB + 2) ? 32'h1f : 32'h0);
      check_val("rst_no_c", 32'({bif.button_c_short, bif.button_c_long}), 32'h0);
    end
    set_raw(5'b00000);
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_val("rst_rel_short", 32'(bif.button_c_short), 32'(t == DB + 3));
      check_val("rst_rel_no_u", 32'(bif.button_u), 32'h0);
    end

    // Bounce: 3-cycle highs never satisfy a 4-cycle debounce.
    for (int i = 0; i < 40; i++) begin
      l_raw = ((i % 6) < 3);
      tick();
      check_val("bounce_l", 32'(bif.button_l), 32'h0);
      check_val("bounce_stable", 32'(bif.buttons_stable), 32'h0);
    end
    l_raw = 1'b0;
    repeat (8) tick();
    check_val("bounce_final_stable", 32'(bif.buttons_stable), 32'h0);

    // Short press: 12 cycles held.
    c_raw = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check_val("short_hold_none", 32'({bif.button_c_short, bif.button_c_long}), 32'h0);
    end
    check_val("short_stable_c", 32'(bif.buttons_stable), 32'h10);
    c_raw = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check_val("short_pulse", 32'(bif.button_c_short), 32'(t == DB + 3));
      check_val("short_no_long", 32'(bif.button_c_long), 32'h0);
    end

    // Long press: registered at edge 7, long fires 20 edges later.
    c_raw = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      check_val("long_pulse", 32'(bif.button_c_long), 32'(t == DB + 3 + LP));
      check_val("long_no_short", 32'(bif.button_c_short), 32'h0);
    end
    c_raw = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check_val("long_rel_none", 32'({bif.button_c_short, bif.button_c_long}), 32'h0);
    end

    // Auto-repeat: P = 7. Raw falls before edge 41, so stable is last high
    // after edge 45 and the last possible pulse edge is 46.
    n_r  = 0;
    n_nr = 0;
    r_raw = 1'b1;
    for (int t = 1; t <= 56; t++) begin
      if (t == 41) r_raw = 1'b0;
      tick();
      check_val("rep_r", 32'(bif.button_r),
                32'((t == 7) || (t >= 17 && t <= 46 && ((t - 17) % RP) == 0)));
      check_val("rep_off_r", 32'(bif_nr.button_r), 32'(t == 7));
      n_r  += int'(bif.button_r);
      n_nr += int'(bif_nr.button_r);
    end
    check_val("rep_count", 32'(n_r), 32'd7);
    check_val("rep_off_count", 32'(n_nr), 32'd1);

    // Mid-press reset: 15 cycles past registration, then reset.
    c_raw = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      check_val("mid_hold_none", 32'({bif.button_c_short, bif.button_c_long}), 32'h0);
    end
    rst = 1'b1;
    #1;
    check_val("mid_rst_outs", 32'(outs()), 32'h0);
    c_raw = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      check_val("mid_after_none", 32'({bif.button_c_short, bif.button_c_long}), 32'h0);
    end
    c_raw = 1'b1;
    repeat (12) tick();
    c_raw = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check_val("mid_clean_short", 32'(bif.button_c_short), 32'(t == DB + 3));
      check_val("mid_clean_no_long", 32'(bif.button_c_long), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
